sha3_padder_param: RTL

Parametrised SHA-3 input padder. It gathers message words from the host-side write interface into one rate-sized block and applies SHA-3 pad10*1 padding with domain byte 0x06. It presents each complete block to the Keccak-f permutation core with a level/acknowledge handshake. It generalises the fixed 32-bit / SHA3-512 padder: input word width is a parameter, and the digest mode (224/256/384/512) is selected per message.

---
 rtl/sha3_pkg.sv | 32 +++
 rtl/sha3_pad_word.sv | 30 +++
 rtl/sha3_padder_param.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/sha3_pkg.sv
// Shared types and constants for the parametrised SHA-3 padder: digest modes,
// rate lookup, pad bytes and the block FSM states.
package sha3_pkg;

  localparam int         MAX_RATE   = 1152;
  localparam logic [7:0] PAD_DOMAIN = 8'h06;
  localparam logic [7:0] PAD_FINAL  = 8'h80;

  typedef enum logic [1:0] {
    MODE_224 = 2'b00,
    MODE_256 = 2'b01,
    MODE_384 = 2'b10,
    MODE_512 = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_ACCEPT    = 2'd0,
    ST_FULL      = 2'd1,
    ST_FULL_LAST = 2'd2
  } state_e;

  // Sponge rate in bits for each digest mode.
  function automatic int unsigned rate_bits(input mode_e m);
    case (m)
      MODE_224: return 1152;
      MODE_256: return 1088;
      MODE_384: return 832;
      default:  return 576;
    endcase
  endfunction

endpackage

// File: rtl/sha3_pad_word.sv
// Combinational word padder: keeps the leading data bytes of a last word,
// inserts the domain byte right after them and zeroes the tail.
module sha3_pad_word
  import sha3_pkg::*;
#(
  parameter int IN_W = 32,
  parameter int BN_W = $clog2(IN_W/8)
) (
  input  logic [IN_W-1:0] i_word,
  input  logic [BN_W-1:0] i_byte_num,
  input  logic            i_is_last,
  output logic [IN_W-1:0] o_word
);

  localparam int BYTES = IN_W/8;

  // One extra bit keeps the per-byte compares from degenerating into constants.
  logic [BN_W:0] w_bn;
  assign w_bn = {1'b0, i_byte_num};

  for (genvar b = 0; b < BYTES; b++) begin : g_byte
    logic [7:0] w_in_b;
    assign w_in_b = i_word[IN_W-1-8*b -: 8];
    assign o_word[IN_W-1-8*b -: 8] =
      (!i_is_last || ((BN_W+1)'(b) < w_bn)) ? w_in_b     :
      ((BN_W+1)'(b) == w_bn)                ? PAD_DOMAIN :
                                              8'h00;
  end

endmodule

// File: rtl/sha3_padder_param.sv
// SHA-3 input padder: packs IN_W-bit words into a rate-sized block, applies
// pad10*1 with domain 0x06 and hands blocks off with a level/ack handshake.
// Optional input checking: define SHA3_PAD_OVF_CHK_EN.
module sha3_padder_param
  import sha3_pkg::*;
#(
  parameter int IN_W = 32,
  parameter int BN_W = $clog2(IN_W/8)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [1:0]          mode,
  input  logic [IN_W-1:0]     in,
  input  logic [BN_W-1:0]     byte_num,
  input  logic                in_ready,
  input  logic                is_last,
  input  logic                f_ack,
  output logic                buffer_full,
  output logic                out_ready,
  output logic [MAX_RATE-1:0] out,
  output logic                last_block,
  output logic                msg_done,
  output logic                overflow
);

  localparam int BYTES = IN_W/8;
  localparam int CW    = $clog2(MAX_RATE/IN_W + 1);

  state_e              r_state;
  mode_e               r_mode;
  logic                r_first;
  logic [CW-1:0]       r_cnt;
  logic [MAX_RATE-1:0] r_out;
  logic                r_full;
  logic                r_last;
  logic                r_done;

  mode_e               w_mode;
  logic [10:0]         w_rate;
  logic [CW-1:0]       w_nwords;
  logic [10:0]         w_base;
  logic [10:0]         w_fpos;
  logic [BN_W-1:0]     w_bn;
  logic [IN_W-1:0]     w_word;
  logic [MAX_RATE-1:0] w_out_nxt;

  // Mode is taken live only on the first word of a message, then held.
  assign w_mode   = r_first ? mode_e'(mode) : r_mode;
  assign w_rate   = 11'(rate_bits(w_mode));
  assign w_nwords = CW'(rate_bits(w_mode) / IN_W);
  assign w_base   = 11'(MAX_RATE - 1) - 11'(r_cnt) * 11'(IN_W);
  assign w_fpos   = 11'(MAX_RATE) - w_rate + 11'd7;

`ifdef SHA3_PAD_OVF_CHK_EN
  logic w_bn_bad;
  logic r_ovf;

  assign w_bn_bad = is_last && ({1'b0, byte_num} > (BN_W+1)'(BYTES-1));
  assign w_bn     = w_bn_bad ? BN_W'(BYTES-1) : byte_num;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      r_ovf <= 1'b0;
    else if (in_ready && (r_full || w_bn_bad))
      r_ovf <= 1'b1;
  end

  assign overflow = r_ovf;
`else
  assign w_bn     = byte_num;
  assign overflow = 1'b0;
`endif

  sha3_pad_word #(
    .IN_W (IN_W),
    .BN_W (BN_W)
  ) u_pad_word (
    .i_word     (in),
    .i_byte_num (w_bn),
    .i_is_last  (is_last),
    .o_word     (w_word)
  );

  // The final-byte 0x80 may land on the word being written, so merge both here.
  always_comb begin
    w_out_nxt                = r_out;
    w_out_nxt[w_base -: IN_W] = w_word;
    if (is_last)
      w_out_nxt[w_fpos -: 8] = w_out_nxt[w_fpos -: 8] | PAD_FINAL;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_ACCEPT;
      r_mode  <= MODE_224;
      r_first <= 1'b1;
      r_cnt   <= '0;
      r_out   <= '0;
      r_full  <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_ACCEPT: begin
          if (in_ready) begin
            r_out <= w_out_nxt;
            r_cnt <= r_cnt + CW'(1);
            if (r_first) begin
              r_mode  <= mode_e'(mode);
              r_first <= 1'b0;
            end
            if (is_last) begin
              r_state <= ST_FULL_LAST;
              r_full  <= 1'b1;
              r_last  <= 1'b1;
            end else if (r_cnt == w_nwords - CW'(1)) begin
              r_state <= ST_FULL;
              r_full  <= 1'b1;
            end
          end
        end
        ST_FULL, ST_FULL_LAST: begin
          // Words arriving while a block is held are dropped.
          if (f_ack) begin
            r_out   <= '0;
            r_cnt   <= '0;
            r_full  <= 1'b0;
            r_last  <= 1'b0;
            r_state <= ST_ACCEPT;
            if (r_state == ST_FULL_LAST) begin
              r_done  <= 1'b1;
              r_first <= 1'b1;
            end
          end
        end
        default: r_state <= ST_ACCEPT;
      endcase
    end
  end

  assign buffer_full = r_full;
  assign out_ready   = r_full;
  assign out         = r_out;
  assign last_block  = r_last;
  assign msg_done    = r_done;

endmodule
